// File: rtl/dfr_result_streamer.sv
`default_nettype none
// ============================================================================
// Module   : dfr_result_streamer
// Brief    : Drains DFR output memory (port B, 1-cycle latency) as an AXI4-Stream
//            packet with full backpressure and TLAST. Optional macro
//            DFR_RESULT_STREAMER_TUSER_EN adds m_axis_tuser (per-beat sample index).
// Revision : 1.0
// ============================================================================
module dfr_result_streamer #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_samples,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_en,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
`ifdef DFR_RESULT_STREAMER_TUSER_EN
    output logic [ADDR_WIDTH-1:0] m_axis_tuser,
`endif
    output logic                  m_axis_tlast
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] C_ONE = ADDR_WIDTH'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
    logic [ADDR_WIDTH-1:0] infl_idx_q, infl_idx_d;
    logic                  infl_q, infl_d;

    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [1:0]            buf_last_q;
`ifdef DFR_RESULT_STREAMER_TUSER_EN
    logic [ADDR_WIDTH-1:0] buf_user_q [2];
`endif
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic [2:0]            w_occ;

    assign w_pop  = (count_q != 2'd0) && m_axis_tready;
    assign w_push = infl_q;
    // Occupancy after this cycle's pop: buffered entries plus the read in flight.
    assign w_occ  = {1'b0, count_q} + {2'b00, infl_q} - {2'b00, w_pop};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rd_cnt_d   = rd_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        infl_d     = 1'b0;
        infl_idx_d = infl_idx_q;
        w_issue    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    len_d    = num_samples;
                    rd_cnt_d = '0;
                    tx_cnt_d = '0;
                    state_d  = (num_samples == '0) ? S_FINISH : S_STREAM;
                end
            end
            S_STREAM: begin
                if ((rd_cnt_q < len_q) && (w_occ < 3'd2)) begin
                    w_issue    = 1'b1;
                    infl_d     = 1'b1;
                    infl_idx_d = rd_cnt_q;
                    rd_cnt_d   = rd_cnt_q + C_ONE;
                end
                if (w_pop) begin
                    tx_cnt_d = tx_cnt_q + C_ONE;
                    if (tx_cnt_q == len_q - C_ONE) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            infl_q     <= 1'b0;
            infl_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_cnt_q   <= rd_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            infl_q     <= infl_d;
            infl_idx_q <= infl_idx_d;
        end
    end

    // Two-entry output buffer; the read in flight always has a free slot reserved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
`ifdef DFR_RESULT_STREAMER_TUSER_EN
                buf_user_q[i] <= '0;
`endif
            end
            buf_last_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            if (w_push) begin
                buf_data_q[wr_ptr_q] <= mem_data;
                buf_last_q[wr_ptr_q] <= (infl_idx_q == len_q - C_ONE);
`ifdef DFR_RESULT_STREAMER_TUSER_EN
                buf_user_q[wr_ptr_q] <= infl_idx_q;
`endif
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign mem_en        = w_issue;
    assign mem_addr      = rd_cnt_q;
    assign m_axis_tvalid = (count_q != 2'd0);
    assign m_axis_tdata  = buf_data_q[rd_ptr_q];
    assign m_axis_tlast  = m_axis_tvalid & buf_last_q[rd_ptr_q];
`ifdef DFR_RESULT_STREAMER_TUSER_EN
    assign m_axis_tuser  = buf_user_q[rd_ptr_q];
`endif

endmodule
`default_nettype wire

// File: doc/dfr_result_streamer.md
Name: dfr_result_streamer

Overview:
Downstream drain stage for the DFR core. When started, it reads the DFR output memory through its spare read port (port B, 1-cycle read latency) for num_samples consecutive words from address 0. It emits the words as an AXI4-Stream master with full backpressure support and TLAST on the final word. This lets the host or a DMA collect results without word-by-word AXI-Lite reads through the memory window.

Parameters:
ADDR_WIDTH, 14, width of memory address and sample count
DATA_WIDTH, 32, width of result words and stream data

Ports:
clk  input  1  system clock; all logic is rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  level/pulse; sampled when idle to begin a transfer
num_samples  input  ADDR_WIDTH  number of words to stream; captured on accepted start
busy  output  1  high from accepted start until the done pulse (inclusive)
done  output  1  single-cycle pulse when the transfer completes
mem_addr  output  ADDR_WIDTH  read address to output memory port B (registered)
mem_en  output  1  read-issue strobe; data for this address is valid on mem_data the next cycle
mem_data  input  DATA_WIDTH  read data from output memory port B
m_axis_tdata  output  DATA_WIDTH  stream data
m_axis_tvalid  output  1  stream valid
m_axis_tready  input  1  stream ready
m_axis_tlast  output  1  high on the final word of the transfer

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, mem_en=0, mem_addr=0, tvalid=0, tlast=0, tdata=0; buffer cleared; counters=0.
- States:
  - IDLE: on start=1, latch num_samples into len and zero rd_cnt / tx_cnt.
    - If len==0, go to FINISH.
    - Otherwise go to STREAM.
  - STREAM: issue reads and emit beats (rules below). When the beat with tx_cnt==len-1 handshakes (tvalid&tready), go to FINISH.
  - FINISH: done=1 and busy=1 for exactly this one cycle, then go to IDLE.
- Busy is 0 only in IDLE. start is ignored while busy, and num_samples changes during busy are ignored.
- Output buffer: 2-entry FIFO; its head drives tdata/tvalid/tlast.
  - Let occ = FIFO entries + in-flight reads (0 or 1).
  - mem_en=1 in a cycle iff state==STREAM, rd_cnt<len, and occ counting this cycle's pop is <2.
  - mem_addr=rd_cnt during that cycle; rd_cnt increments after each issue.
  - Data returned on mem_data the cycle after mem_en is pushed into the FIFO.
  - The FIFO never overflows, and no read is issued that cannot be stored.
- Latency: if start is accepted at edge E, mem_en for address 0 is high in the cycle after E, and tvalid rises 2 cycles after E.
- Throughput: with tready held at 1, one beat per cycle, no bubbles.
- AXIS rules:
  - Once tvalid=1, tdata and tlast stay stable until handshake.
  - tvalid never depends combinationally on tready.
- tlast=1 exactly on the beat whose tx_cnt==len-1; for len==1 the single beat carries tlast.
- Counters are ADDR_WIDTH wide; len==2^ADDR_WIDTH-1 must work without wrap. Addresses go 0..len-1 only, never beyond.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Reset mid-transfer aborts immediately:
  - no done pulse;
  - the stream drops tvalid without completing the packet (accepted upstream behaviour).

Optional Feature:
Macro DFR_RESULT_STREAMER_TUSER_EN.
- Defined: adds port m_axis_tuser (output, ADDR_WIDTH) carrying the sample index (0..len-1) of the current beat. It is stored per FIFO entry, stable with tdata, and reset to 0.
- Undefined: the port is absent and there is no index storage; all other behaviour is identical.

Test Plan:
1. Memory preloaded 0x100..0x103, num_samples=4, tready=1, start pulse -> beats 0x100,0x101,0x102,0x103 on 4 consecutive cycles starting 2 cycles after start; tlast only on 0x103; done one cycle after the last handshake; busy then 0.
2. Same data, tready toggling 1,0,0,1,0,1,1 -> the same 4 words in order with no loss or duplication; tdata stable while stalled; mem_en never issued with occ==2; at most 4 mem_en pulses, addresses 0..3.
3. num_samples=0, start -> no tvalid, no mem_en; busy=1 and done=1 in the same single cycle, then idle.
4. num_samples=1, data 0xDEADBEEF -> one beat 0xDEADBEEF with tlast=1, then done.
5. num_samples=3 and streaming; assert start again with num_samples=9 mid-transfer -> ignored, exactly 3 beats; then assert rst after beat 1 of a new 5-word run -> all outputs 0 immediately, no done, next start streams from address 0.
6. With DFR_RESULT_STREAMER_TUSER_EN defined, num_samples=3 under random backpressure -> tuser 0,1,2 aligned with the corresponding tdata.
